// File: rtl/vga_sync_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_timing
// Description : VGA raster timing generator with column/row phase FSMs,
//               registered sync pulses, active flags, coordinates and a
//               frame-start strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int CW       = 10
) (
    input  logic          CLK,
    input  logic          i_Rst,
    input  logic          i_Enable,
    output logic          o_HSync_Active,
    output logic          o_VSync_Active,
    output logic          o_HSync,
    output logic          o_VSync,
    output logic [CW-1:0] o_Col_Count,
    output logic [CW-1:0] o_Row_Count,
    output logic          o_Frame_Start
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] c_H_LAST       = CW'(c_H_TOTAL - 1);
    localparam logic [CW-1:0] c_H_FP_START   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] c_H_SYNC_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] c_H_BP_START   = CW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [CW-1:0] c_V_LAST       = CW'(c_V_TOTAL - 1);
    localparam logic [CW-1:0] c_V_FP_START   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] c_V_SYNC_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] c_V_BP_START   = CW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic c_SYNC_ON  = 1'(SYNC_POL);
    localparam logic c_SYNC_OFF = ~c_SYNC_ON;

    localparam logic [1:0] c_ST_ACTIVE = 2'd0;
    localparam logic [1:0] c_ST_FRONT  = 2'd1;
    localparam logic [1:0] c_ST_SYNC   = 2'd2;
    localparam logic [1:0] c_ST_BACK   = 2'd3;

    logic [CW-1:0] r_col_q, w_col_d;
    logic [CW-1:0] r_row_q, w_row_d;
    logic [1:0]    r_h_state_q, w_h_state_d;
    logic [1:0]    r_v_state_q, w_v_state_d;
    logic          r_h_act_q, w_h_act_d;
    logic          r_v_act_q, w_v_act_d;
    logic          r_hsync_q, w_hsync_d;
    logic          r_vsync_q, w_vsync_d;
    logic          r_frame_q, w_frame_d;
    logic          w_col_wrap;

    // Phase advances when the upcoming count lands exactly on the next boundary.
    function automatic logic [1:0] f_phase_next(
        input logic [1:0]    state,
        input logic [CW-1:0] cnt,
        input logic [CW-1:0] fp_start,
        input logic [CW-1:0] sync_start,
        input logic [CW-1:0] bp_start
    );
        logic [1:0] nxt;
        nxt = state;
        case (state)
            c_ST_ACTIVE: if (cnt == fp_start)   nxt = c_ST_FRONT;
            c_ST_FRONT:  if (cnt == sync_start) nxt = c_ST_SYNC;
            c_ST_SYNC:   if (cnt == bp_start)   nxt = c_ST_BACK;
            default:     if (cnt == '0)         nxt = c_ST_ACTIVE;
        endcase
        return nxt;
    endfunction

    always_comb begin
        w_col_d     = r_col_q;
        w_row_d     = r_row_q;
        w_h_state_d = r_h_state_q;
        w_v_state_d = r_v_state_q;
        w_h_act_d   = r_h_act_q;
        w_v_act_d   = r_v_act_q;
        w_hsync_d   = r_hsync_q;
        w_vsync_d   = r_vsync_q;
        w_frame_d   = r_frame_q;
        w_col_wrap  = (r_col_q == c_H_LAST);

        if (i_Enable) begin
            w_col_d     = w_col_wrap ? '0 : r_col_q + CW'(1);
            w_h_state_d = f_phase_next(r_h_state_q, w_col_d, c_H_FP_START,
                                       c_H_SYNC_START, c_H_BP_START);
            if (w_col_wrap) begin
                w_row_d     = (r_row_q == c_V_LAST) ? '0 : r_row_q + CW'(1);
                w_v_state_d = f_phase_next(r_v_state_q, w_row_d, c_V_FP_START,
                                           c_V_SYNC_START, c_V_BP_START);
            end
            // Outputs are decoded from the next state so they align with the counters.
            w_h_act_d = (w_h_state_d == c_ST_ACTIVE);
            w_v_act_d = (w_v_state_d == c_ST_ACTIVE);
            w_hsync_d = (w_h_state_d == c_ST_SYNC) ? c_SYNC_ON : c_SYNC_OFF;
            w_vsync_d = (w_v_state_d == c_ST_SYNC) ? c_SYNC_ON : c_SYNC_OFF;
            w_frame_d = (w_col_d == '0) && (w_row_d == '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (i_Rst) begin
            r_col_q     <= c_H_LAST;
            r_row_q     <= c_V_LAST;
            r_h_state_q <= c_ST_BACK;
            r_v_state_q <= c_ST_BACK;
            r_h_act_q   <= 1'b0;
            r_v_act_q   <= 1'b0;
            r_hsync_q   <= c_SYNC_OFF;
            r_vsync_q   <= c_SYNC_OFF;
            r_frame_q   <= 1'b0;
        end else begin
            r_col_q     <= w_col_d;
            r_row_q     <= w_row_d;
            r_h_state_q <= w_h_state_d;
            r_v_state_q <= w_v_state_d;
            r_h_act_q   <= w_h_act_d;
            r_v_act_q   <= w_v_act_d;
            r_hsync_q   <= w_hsync_d;
            r_vsync_q   <= w_vsync_d;
            r_frame_q   <= w_frame_d;
        end
    end

    assign o_HSync_Active = r_h_act_q;
    assign o_VSync_Active = r_v_act_q;
    assign o_HSync        = r_hsync_q;
    assign o_VSync        = r_vsync_q;
    assign o_Col_Count    = r_col_q;
    assign o_Row_Count    = r_row_q;
    assign o_Frame_Start  = r_frame_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_timing.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_timing
// Description : Randomized bench for vga_sync_timing against a position-based
//               reference model, using default, tiny and mid-size timings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic en  = 1'b0;

    logic       d0_ha, d0_va, d0_hs, d0_vs, d0_fs;
    logic [9:0] d0_col, d0_row;
    logic       d1_ha, d1_va, d1_hs, d1_vs, d1_fs;
    logic [2:0] d1_col, d1_row;
    logic       d2_ha, d2_va, d2_hs, d2_vs, d2_fs;
    logic [4:0] d2_col, d2_row;

    vga_sync_timing u_dut0 (
        .CLK(clk), .i_Rst(rst), .i_Enable(en),
        .o_HSync_Active(d0_ha), .o_VSync_Active(d0_va),
        .o_HSync(d0_hs), .o_VSync(d0_vs),
        .o_Col_Count(d0_col), .o_Row_Count(d0_row), .o_Frame_Start(d0_fs)
    );

    vga_sync_timing #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1), .CW(3)
    ) u_dut1 (
        .CLK(clk), .i_Rst(rst), .i_Enable(en),
        .o_HSync_Active(d1_ha), .o_VSync_Active(d1_va),
        .o_HSync(d1_hs), .o_VSync(d1_vs),
        .o_Col_Count(d1_col), .o_Row_Count(d1_row), .o_Frame_Start(d1_fs)
    );

    vga_sync_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(0), .CW(5)
    ) u_dut2 (
        .CLK(clk), .i_Rst(rst), .i_Enable(en),
        .o_HSync_Active(d2_ha), .o_VSync_Active(d2_va),
        .o_HSync(d2_hs), .o_VSync(d2_vs),
        .o_Col_Count(d2_col), .o_Row_Count(d2_row), .o_Frame_Start(d2_fs)
    );

    int c_HA[3] = '{640, 4, 16};
    int c_HF[3] = '{16, 1, 2};
    int c_HS[3] = '{96, 2, 4};
    int c_HB[3] = '{48, 1, 2};
    int c_VA[3] = '{480, 3, 10};
    int c_VF[3] = '{10, 1, 2};
    int c_VS[3] = '{2, 1, 2};
    int c_VB[3] = '{33, 1, 3};
    int c_POL[3] = '{0, 1, 0};

    int mc[3];
    int mr[3];
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int h_total(int k);
        return c_HA[k] + c_HF[k] + c_HS[k] + c_HB[k];
    endfunction

    function automatic int v_total(int k);
        return c_VA[k] + c_VF[k] + c_VS[k] + c_VB[k];
    endfunction

    // Expected outputs purely from the modelled position and the timing rules.
    function automatic logic [31:0] model_exp(int k);
        logic ha, va, hs, vs, fs, pol;
        int   c, r;
        c   = mc[k];
        r   = mr[k];
        pol = (c_POL[k] != 0);
        ha  = (c < c_HA[k]);
        va  = (r < c_VA[k]);
        hs  = (c >= c_HA[k] + c_HF[k] && c < c_HA[k] + c_HF[k] + c_HS[k]) ? pol : ~pol;
        vs  = (r >= c_VA[k] + c_VF[k] && r < c_VA[k] + c_VF[k] + c_VS[k]) ? pol : ~pol;
        fs  = (c == 0) && (r == 0);
        return {7'd0, ha, va, hs, vs, fs, 10'(c), 10'(r)};
    endfunction

    function automatic logic [31:0] dut_obs(int k);
        case (k)
            0:       return {7'd0, d0_ha, d0_va, d0_hs, d0_vs, d0_fs, d0_col, d0_row};
            1:       return {7'd0, d1_ha, d1_va, d1_hs, d1_vs, d1_fs, 10'(d1_col), 10'(d1_row)};
            default: return {7'd0, d2_ha, d2_va, d2_hs, d2_vs, d2_fs, 10'(d2_col), 10'(d2_row)};
        endcase
    endfunction

    task automatic step(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                mc[k] = h_total(k) - 1;
                mr[k] = v_total(k) - 1;
            end else if (e) begin
                if (mc[k] == h_total(k) - 1) begin
                    mc[k] = 0;
                    mr[k] = (mr[k] == v_total(k) - 1) ? 0 : mr[k] + 1;
                end else begin
                    mc[k] = mc[k] + 1;
                end
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            check($sformatf("dut%0d_state", k), dut_obs(k), model_exp(k));
    endtask

    initial begin
        int ha_cnt;
        int hs_lo;
        int hs_first;
        int hs_last;
        int p1;
        int p2;

        repeat (3) step(1'b1, 1'b0);
        check("rst_col", 32'(d0_col), 32'd799);
        check("rst_row", 32'(d0_row), 32'd524);
        check("rst_flags", {27'd0, d0_ha, d0_va, d0_hs, d0_vs, d0_fs}, 32'b00110);

        step(1'b0, 1'b1);
        check("first_pos", {12'd0, d0_col, d0_row}, 32'd0);
        check("first_fs", 32'(d0_fs), 32'd1);
        check("first_active", {30'd0, d0_ha, d0_va}, 32'd3);

        // One full line starting from column 0.
        ha_cnt   = 1;
        hs_lo    = 0;
        hs_first = -1;
        hs_last  = -1;
        step(1'b0, 1'b1);
        check("fs_drop", 32'(d0_fs), 32'd0);
        for (int i = 0; i < 798; i++) begin
            if (d0_ha) ha_cnt++;
            if (!d0_hs) begin
                hs_lo++;
                if (hs_first < 0) hs_first = int'(d0_col);
                hs_last = int'(d0_col);
            end
            step(1'b0, 1'b1);
        end
        if (d0_ha) ha_cnt++;
        if (!d0_hs) hs_lo++;
        check("line_last_col", 32'(d0_col), 32'd799);
        step(1'b0, 1'b1);
        check("line_wrap", {12'd0, d0_col, d0_row}, {12'd0, 10'd0, 10'd1});
        check("hact_count", ha_cnt, 640);
        check("hsync_count", hs_lo, 96);
        check("hsync_first", hs_first, 656);
        check("hsync_last", hs_last, 751);

        // Random enable gaps and occasional mid-frame resets.
        for (int i = 0; i < 6000; i++)
            step(1'b0 | ($urandom_range(0, 599) == 0), ($urandom_range(0, 7) != 0));

        // Freeze at column 655, then resume into horizontal sync.
        for (int i = 0; i < 1700 && d0_col != 10'd655; i++) step(1'b0, 1'b1);
        check("reach_655", 32'(d0_col), 32'd655);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            check("hold_col", 32'(d0_col), 32'd655);
            check("hold_hsync", 32'(d0_hs), 32'd1);
        end
        step(1'b0, 1'b1);
        check("resume_col", 32'(d0_col), 32'd656);
        check("resume_hsync", 32'(d0_hs), 32'd0);

        // Mid-line reset overrides enable.
        for (int i = 0; i < 1700 && d0_col != 10'd300; i++) step(1'b0, 1'b1);
        check("reach_300", 32'(d0_col), 32'd300);
        step(1'b1, 1'b1);
        check("midrst_pos", {12'd0, d0_col, d0_row}, {12'd0, 10'd799, 10'd524});
        check("midrst_flags", {27'd0, d0_ha, d0_va, d0_hs, d0_vs, d0_fs}, 32'b00110);
        step(1'b0, 1'b1);
        check("midrst_restart", {11'd0, d0_fs, d0_col, d0_row}, {11'd0, 1'b1, 20'd0});

        // Frame periods of the reduced timings, all instances start at (0,0) here.
        p1 = -1;
        p2 = -1;
        for (int i = 1; i <= 450; i++) begin
            step(1'b0, 1'b1);
            if (d1_fs && p1 < 0) p1 = i;
            if (d2_fs && p2 < 0) p2 = i;
        end
        check("period_small", p1, 48);
        check("period_mid", p2, 408);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
